// File: rtl/n0prime_crt_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : n0prime_crt_arbiter_if
// Brief   : Bundle between the CRT p/q modexp controllers, the shared
//           n0prime engine and the arbiter that sits between them.
//           slave  = arbiter view, master = requester/engine view.
// Revision: 1.0  initial release
// ============================================================================
interface n0prime_crt_arbiter_if #(
   parameter int NW = 512,
   parameter int W  = 32
);
   // requester side
   logic          req_p;
   logic [NW-1:0] n_p;
   logic          req_q;
   logic [NW-1:0] n_q;
   logic          ack_p;
   logic          ack_q;
   logic [W-1:0]  res_p;
   logic [W-1:0]  res_q;
   logic          err_p;
   logic          err_q;
   logic          busy;
   // engine side
   logic [NW-1:0] eng_n;
   logic          eng_start;
   logic          eng_done;
   logic [W-1:0]  eng_result;

   modport slave (
      input  req_p, n_p, req_q, n_q, eng_done, eng_result,
      output ack_p, ack_q, res_p, res_q, err_p, err_q, busy, eng_n, eng_start
   );

   modport master (
      output req_p, n_p, req_q, n_q, eng_done, eng_result,
      input  ack_p, ack_q, res_p, res_q, err_p, err_q, busy, eng_n, eng_start
   );
endinterface
`default_nettype wire

// File: rtl/n0prime_crt_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : n0prime_crt_arbiter
// Brief   : Shares one n0prime engine between the p and q CRT halves.
//           Latches each requester's modulus, launches the engine with a
//           one-cycle start, returns the result (or a timeout error) as a
//           registered pulse. Round-robin on contention.
// Revision: 1.0  initial release
// ============================================================================
module n0prime_crt_arbiter #(
   parameter int NW      = 512,
   parameter int W       = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   n0prime_crt_arbiter_if.slave bus
);

   localparam int            CW         = $clog2(TIMEOUT);
   localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic          r_pend_p;
   logic          r_pend_q;
   logic [NW-1:0] r_nreg_p;
   logic [NW-1:0] r_nreg_q;
   logic [NW-1:0] r_eng_n;
   logic          r_owner_q;   // 1: q is (or was last) in service
   logic          r_rr_q;      // 1: q was granted last, so p wins a tie
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_res_p;
   logic [W-1:0]  r_res_q;
   logic          r_ack_p;
   logic          r_ack_q;
   logic          r_err_p;
   logic          r_err_q;

   logic          w_grant;
   logic          w_pick_q;
   logic          w_done;
   logic          w_timeout;
   logic          w_take_p;
   logic          w_take_q;

   // A requester already pending or in service cannot queue a second job;
   // in the ack/err cycle the FSM is back in IDLE, so a re-request is taken.
   assign w_take_p = bus.req_p && !r_pend_p && !((r_state != S_IDLE) && !r_owner_q);
   assign w_take_q = bus.req_q && !r_pend_q && !((r_state != S_IDLE) &&  r_owner_q);

   // Next-state decode; eng_done is only looked at while waiting.
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_pick_q    = 1'b0;
      w_done      = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_pend_p || r_pend_q) begin
               w_grant     = 1'b1;
               w_pick_q    = r_pend_q && (!r_pend_p || !r_rr_q);
               w_state_nxt = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (bus.eng_done) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_cnt == C_CNT_LAST) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Request intake: latch modulus on acceptance, clear pending on grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pend_p <= 1'b0;
         r_pend_q <= 1'b0;
         r_nreg_p <= '0;
         r_nreg_q <= '0;
      end else begin
         if (w_grant && !w_pick_q) begin
            r_pend_p <= 1'b0;
         end else if (w_take_p) begin
            r_pend_p <= 1'b1;
            r_nreg_p <= bus.n_p;
         end
         if (w_grant && w_pick_q) begin
            r_pend_q <= 1'b0;
         end else if (w_take_q) begin
            r_pend_q <= 1'b1;
            r_nreg_q <= bus.n_q;
         end
      end
   end

   // Grant bookkeeping: owner, engine operand (held until the next grant)
   // and the watchdog counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_owner_q <= 1'b0;
         r_eng_n   <= '0;
         r_cnt     <= '0;
      end else begin
         if (w_grant) begin
            r_owner_q <= w_pick_q;
            r_eng_n   <= w_pick_q ? r_nreg_q : r_nreg_p;
         end
         if (r_state == S_LAUNCH) begin
            r_cnt <= '0;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Completion: registered ack/err pulses, result capture, round-robin update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ack_p <= 1'b0;
         r_ack_q <= 1'b0;
         r_err_p <= 1'b0;
         r_err_q <= 1'b0;
         r_res_p <= '0;
         r_res_q <= '0;
         r_rr_q  <= 1'b1;
      end else begin
         r_ack_p <= w_done    && !r_owner_q;
         r_ack_q <= w_done    &&  r_owner_q;
         r_err_p <= w_timeout && !r_owner_q;
         r_err_q <= w_timeout &&  r_owner_q;
         if (w_done && !r_owner_q) begin
            r_res_p <= bus.eng_result;
         end
         if (w_done && r_owner_q) begin
            r_res_q <= bus.eng_result;
         end
         if (w_done || w_timeout) begin
            r_rr_q <= r_owner_q;
         end
      end
   end

   assign bus.ack_p     = r_ack_p;
   assign bus.ack_q     = r_ack_q;
   assign bus.err_p     = r_err_p;
   assign bus.err_q     = r_err_q;
   assign bus.res_p     = r_res_p;
   assign bus.res_q     = r_res_q;
   assign bus.eng_n     = r_eng_n;
   assign bus.eng_start = (r_state == S_LAUNCH);
   // Held through the completion pulse so it drops the cycle after it.
   assign bus.busy      = (r_state != S_IDLE) || r_pend_p || r_pend_q ||
                          r_ack_p || r_ack_q || r_err_p || r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_n0prime_crt_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_n0prime_crt_arbiter
// Brief   : Scoreboard bench for n0prime_crt_arbiter. A transaction-level
//           model predicts accepted jobs, grant order and completion timing;
//           a bench engine answers eng_start with -(n^-1) mod 2^W.
// Revision: 1.0  initial release
// ============================================================================
module tb_n0prime_crt_arbiter;

   localparam int NW      = 512;
   localparam int W       = 32;
   localparam int TIMEOUT = 256;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   n0prime_crt_arbiter_if #(.NW(NW), .W(W)) bus ();

   n0prime_crt_arbiter #(.NW(NW), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input bit ok, input string nm,
                      input logic [NW-1:0] act, input logic [NW-1:0] exp);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // -(n^-1) mod 2^W by Newton iteration (n odd).
   function automatic logic [W-1:0] n0p(input logic [W-1:0] n);
      logic [W-1:0] x;
      x = n;
      for (int i = 0; i < 6; i++) x = x * (W'(2) - n * x);
      return -x;
   endfunction

   function automatic logic [NW-1:0] rnd_n();
      logic [NW-1:0] v;
      for (int i = 0; i < NW / 32; i++) v[i*32 +: 32] = $urandom;
      v[0] = 1'b1;
      return v;
   endfunction

   // ---------------- engine latency control ----------------
   int lat_plan[$];          // directed latencies, consumed one per launch
   int lat_mode = 0;         // 0: lat_fix, 1: random mix
   int lat_fix  = 10;        // 0 means the engine never answers
   int go_cnt   = 0;
   int go_lat   = 0;
   int inj_cnt  = 0;         // stray done pulses requested by the driver

   function automatic int pick_lat();
      int r;
      if (lat_plan.size() > 0) return lat_plan.pop_front();
      if (lat_mode == 0) return lat_fix;
      r = $urandom_range(0, 19);
      if (r == 0) return 0;
      if (r == 1) return TIMEOUT;
      return $urandom_range(1, 40);
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      bit           who_q;
      bit           is_err;
      int           cyc;
      logic [W-1:0] rp;
      logic [W-1:0] rq;
   } exp_t;
   exp_t expq[$];

   bit            out_p = 0, out_q = 0;    // job outstanding per requester
   bit            pv_p = 0, pv_q = 0;      // waiting for a grant
   logic [NW-1:0] pn_p, pn_q;
   int            pc_p = 0, pc_q = 0;      // acceptance cycle
   bit            svc = 0;                 // engine job in flight
   bit            last_q = 1;
   bit            prev_idle = 1, prev_elig = 0;
   logic [NW-1:0] own_n = '0;
   logic [W-1:0]  mres_p = '0, mres_q = '0;
   int            n_starts = 0;
   int            n_errs = 0;

   // Model update, one step per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      bit            ep, eq, wq;
      logic [NW-1:0] nexp;
      int            lat;
      exp_t          e;
      if (reset) begin
         out_p = 0; out_q = 0; pv_p = 0; pv_q = 0; svc = 0; last_q = 1;
         prev_idle = 1; prev_elig = 0; mres_p = '0; mres_q = '0;
         expq.delete();
      end else begin
         // a launch follows the first free cycle that sees a visible request
         chk(bus.eng_start === (prev_idle && prev_elig), "start_timing",
             NW'(bus.eng_start), NW'(prev_idle && prev_elig));
         if (bus.ack_p || bus.err_p) begin out_p = 0; svc = 0; end
         if (bus.ack_q || bus.err_q) begin out_q = 0; svc = 0; end
         if (bus.eng_start) begin
            ep = pv_p && (pc_p <= cyc - 2);
            eq = pv_q && (pc_q <= cyc - 2);
            if (!(ep || eq)) begin
               chk(1'b0, "start_without_request", NW'(1), NW'(0));
            end else begin
               wq   = eq && (!ep || !last_q);
               nexp = wq ? pn_q : pn_p;
               chk(bus.eng_n === nexp, "eng_n_at_launch", bus.eng_n, nexp);
               if (wq) pv_q = 0; else pv_p = 0;
               own_n  = nexp;
               svc    = 1;
               last_q = wq;
               n_starts++;
               lat    = pick_lat();
               go_lat = lat;
               go_cnt++;
               e.who_q = wq;
               if (lat >= 1 && lat <= TIMEOUT) begin
                  e.is_err = 0;
                  e.cyc    = cyc + lat + 1;
                  if (wq) mres_q = n0p(nexp[W-1:0]); else mres_p = n0p(nexp[W-1:0]);
               end else begin
                  e.is_err = 1;
                  e.cyc    = cyc + TIMEOUT + 1;
               end
               e.rp = mres_p;
               e.rq = mres_q;
               expq.push_back(e);
            end
         end else if (svc) begin
            chk(bus.eng_n === own_n, "eng_n_hold", bus.eng_n, own_n);
         end
         if (bus.req_p && !out_p) begin out_p = 1; pv_p = 1; pn_p = bus.n_p; pc_p = cyc; end
         if (bus.req_q && !out_q) begin out_q = 1; pv_q = 1; pn_q = bus.n_q; pc_q = cyc; end
         prev_idle = !svc;
         prev_elig = (pv_p && (pc_p <= cyc - 1)) || (pv_q && (pc_q <= cyc - 1));
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      int   nev;
      exp_t e;
      if (!reset) begin
         nev = int'(bus.ack_p) + int'(bus.ack_q) + int'(bus.err_p) + int'(bus.err_q);
         if (nev > 0) begin
            if (bus.err_p || bus.err_q) n_errs++;
            chk(nev == 1, "single_completion_pulse", NW'(nev), NW'(1));
            if (expq.size() == 0) begin
               chk(1'b0, "unexpected_completion", NW'(nev), NW'(0));
            end else begin
               e = expq.pop_front();
               chk((bus.ack_q || bus.err_q) == e.who_q, "completion_owner",
                   NW'(bus.ack_q || bus.err_q), NW'(e.who_q));
               chk((bus.err_p || bus.err_q) == e.is_err, "completion_kind",
                   NW'(bus.err_p || bus.err_q), NW'(e.is_err));
               chk(cyc == e.cyc, "completion_cycle", NW'(cyc), NW'(e.cyc));
               chk(bus.res_p === e.rp, "res_p", NW'(bus.res_p), NW'(e.rp));
               chk(bus.res_q === e.rq, "res_q", NW'(bus.res_q), NW'(e.rq));
            end
         end else if (expq.size() > 0 && cyc > expq[0].cyc) begin
            chk(1'b0, "missing_completion", NW'(cyc), NW'(expq[0].cyc));
            void'(expq.pop_front());
         end
      end
   end

   // ---------------- bench engine ----------------
   initial begin
      int            rem;
      int            seen;
      int            inj_seen;
      bit            dn;
      logic [NW-1:0] en;
      rem = 0; seen = 0; inj_seen = 0; en = '0;
      bus.eng_done   = 1'b0;
      bus.eng_result = '0;
      forever begin
         @(posedge clk);
         #1;
         dn = 0;
         if (go_cnt != seen) begin
            seen = go_cnt;
            rem  = go_lat;
            en   = bus.eng_n;
         end
         if (rem > 0) begin
            if (rem == 1) dn = 1;
            rem--;
         end
         if (inj_cnt != inj_seen) begin
            inj_seen++;
            dn = 1;
         end
         bus.eng_done   = dn;
         bus.eng_result = dn ? n0p(en[W-1:0]) : W'($urandom);
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      bus.req_p = 1'b0;
      bus.req_q = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_quiet(input int max);
      int t;
      t = 0;
      tick();
      while ((expq.size() != 0 || out_p || out_q || bus.busy) && t < max) begin
         tick();
         t++;
      end
      if (t >= max) chk(1'b0, "quiesce_timeout", NW'(t), NW'(max));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int            s0, e0, who, prev_who, t;
      logic [NW-1:0] v, vq;
      logic [W-1:0]  saved;
      bus.req_p = 0; bus.req_q = 0; bus.n_p = '0; bus.n_q = '0;

      // reset state
      tick(); tick();
      chk(bus.ack_p === 0 && bus.ack_q === 0, "rst_ack", NW'({bus.ack_p, bus.ack_q}), '0);
      chk(bus.err_p === 0 && bus.err_q === 0, "rst_err", NW'({bus.err_p, bus.err_q}), '0);
      chk(bus.res_p === '0, "rst_res_p", NW'(bus.res_p), '0);
      chk(bus.res_q === '0, "rst_res_q", NW'(bus.res_q), '0);
      chk(bus.busy === 0 && bus.eng_start === 0, "rst_busy_start", NW'({bus.busy, bus.eng_start}), '0);
      chk(bus.eng_n === '0, "rst_eng_n", bus.eng_n, '0);
      reset = 1'b0;

      // 1: single p request, latency 34
      lat_mode = 0; lat_fix = 34; s0 = n_starts;
      tick(); v = rnd_n(); v[31:0] = 32'h3; bus.req_p = 1; bus.n_p = v;
      wait_quiet(200);
      chk(n_starts - s0 == 1, "t1_start_count", NW'(n_starts - s0), NW'(1));
      chk(bus.res_p === 32'h5555_5555, "t1_res_p", NW'(bus.res_p), NW'(32'h5555_5555));
      chk(bus.res_q === '0, "t1_res_q", NW'(bus.res_q), '0);

      // 2: simultaneous p (n=1) and q (n=3) after reset
      do_reset();
      lat_fix = 20; s0 = n_starts;
      tick(); v = rnd_n(); v[31:0] = 32'h1; vq = rnd_n(); vq[31:0] = 32'h3;
      bus.req_p = 1; bus.n_p = v; bus.req_q = 1; bus.n_q = vq;
      wait_quiet(300);
      chk(n_starts - s0 == 2, "t2_start_count", NW'(n_starts - s0), NW'(2));
      chk(bus.res_p === 32'hFFFF_FFFF, "t2_res_p", NW'(bus.res_p), NW'(32'hFFFF_FFFF));
      chk(bus.res_q === 32'h5555_5555, "t2_res_q", NW'(bus.res_q), NW'(32'h5555_5555));

      // 3: fairness, both re-request on every ack
      lat_fix = 6; prev_who = -1;
      tick(); bus.req_p = 1; bus.n_p = rnd_n(); bus.req_q = 1; bus.n_q = rnd_n();
      for (int k = 0; k < 8; k++) begin
         t = 0;
         tick();
         while (!(bus.ack_p || bus.ack_q) && t < 100) begin tick(); t++; end
         if (t >= 100) begin
            chk(1'b0, "t3_ack_timeout", NW'(t), NW'(100));
         end else begin
            who = int'(bus.ack_q);
            if (k == 0) chk(who == 0, "t3_first_grant", NW'(who), NW'(0));
            else        chk(who != prev_who, "t3_alternation", NW'(who), NW'(1 - prev_who));
            prev_who = who;
            if (who == 1) begin bus.req_q = 1; bus.n_q = rnd_n(); end
            else          begin bus.req_p = 1; bus.n_p = rnd_n(); end
         end
      end
      wait_quiet(200);

      // 4: hung engine on p, then q completes; then the timeout boundary
      saved = bus.res_p; e0 = n_errs;
      lat_plan.push_back(0); lat_plan.push_back(12);
      tick(); bus.req_p = 1; bus.n_p = rnd_n();
      tick(); tick();
      tick(); vq = rnd_n(); bus.req_q = 1; bus.n_q = vq;
      wait_quiet(700);
      chk(bus.res_p === saved, "t4_res_p_unchanged", NW'(bus.res_p), NW'(saved));
      chk(bus.res_q === n0p(vq[W-1:0]), "t4_res_q", NW'(bus.res_q), NW'(n0p(vq[W-1:0])));
      chk(n_errs - e0 == 1, "t4_err_count", NW'(n_errs - e0), NW'(1));
      e0 = n_errs;
      lat_plan.push_back(TIMEOUT); lat_plan.push_back(TIMEOUT + 1);
      tick(); bus.req_q = 1; bus.n_q = rnd_n();
      tick(); bus.req_p = 1; bus.n_p = rnd_n();
      wait_quiet(1000);
      chk(n_errs - e0 == 1, "t4_boundary_err_count", NW'(n_errs - e0), NW'(1));

      // 5: duplicate requests and a stray done in IDLE
      lat_plan.push_back(20); s0 = n_starts;
      tick(); bus.req_p = 1; bus.n_p = rnd_n();
      tick(); bus.req_p = 1; bus.n_p = rnd_n();
      tick();
      tick(); bus.req_p = 1; bus.n_p = rnd_n();
      wait_quiet(200);
      chk(n_starts - s0 == 1, "t5_dup_start_count", NW'(n_starts - s0), NW'(1));
      s0 = n_starts; saved = bus.res_p;
      inj_cnt++;
      repeat (5) tick();
      chk(n_starts == s0, "t5_stale_no_start", NW'(n_starts), NW'(s0));
      chk(bus.busy === 0, "t5_stale_busy", NW'(bus.busy), '0);
      chk(bus.res_p === saved, "t5_stale_res", NW'(bus.res_p), NW'(saved));

      // 6: reset in the middle of WAIT
      lat_plan.push_back(60);
      tick(); bus.req_p = 1; bus.n_p = rnd_n();
      t = 0;
      tick();
      while (!bus.eng_start && t < 20) begin tick(); t++; end
      chk(t < 20, "t6_launch_seen", NW'(t), NW'(20));
      repeat (10) tick();
      #2 reset = 1'b1;
      #1;
      chk({bus.ack_p, bus.ack_q, bus.err_p, bus.err_q, bus.busy, bus.eng_start} === 6'b0,
          "t6_async_ctrl", NW'({bus.ack_p, bus.ack_q, bus.err_p, bus.err_q, bus.busy, bus.eng_start}), '0);
      chk(bus.res_p === '0 && bus.res_q === '0, "t6_async_res", NW'({bus.res_p, bus.res_q}), '0);
      chk(bus.eng_n === '0, "t6_async_eng_n", bus.eng_n, '0);
      tick(); tick();
      reset = 1'b0;
      repeat (70) tick();
      chk(bus.res_p === '0 && bus.busy === 0, "t6_late_done_ignored",
          NW'({bus.res_p, bus.busy}), '0);
      lat_plan.push_back(15);
      tick(); vq = rnd_n(); bus.req_q = 1; bus.n_q = vq;
      wait_quiet(200);
      chk(bus.res_q === n0p(vq[W-1:0]), "t6_fresh_q", NW'(bus.res_q), NW'(n0p(vq[W-1:0])));

      // random traffic
      lat_mode = 1;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if ($urandom_range(0, 7) == 0) begin bus.req_p = 1; bus.n_p = rnd_n(); end
         if ($urandom_range(0, 7) == 0) begin bus.req_q = 1; bus.n_q = rnd_n(); end
      end
      wait_quiet(3000);
      chk(expq.size() == 0, "drain", NW'(expq.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
